// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: bus widths, direction codes,
// master identifiers and the arbiter state encoding.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_arb_select.sv
// Combinational winner selection: round-robin between m0/m1 with a cap on how many
// consecutive grants one master may take while the other is waiting.
module arb_select
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          last,
    input  logic [BW-1:0] burst_cnt,
    output logic          valid,
    output logic          winner,
    output logic [BW-1:0] next_burst_cnt
);

    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    always_comb begin
        valid  = m0_req | m1_req;
        winner = ARB_M0;
        // A zero count (fresh from reset) means no burst is in progress, so the tie goes to !last.
        if (m0_req && m1_req) begin
            winner = ((burst_cnt != '0) && (burst_cnt < BURST_MAX)) ? last : ~last;
        end else if (m1_req) begin
            winner = ARB_M1;
        end

        if (winner == last) begin
            next_burst_cnt = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + BW'(1);
        end else begin
            next_burst_cnt = BW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter and sequencer: grants the shared device bus, holds each access
// for ACCESS_CYCLES cycles, then returns a registered ack (and read data) to the owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH    = BUS_DATA_WIDTH,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_BURST     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_rw_,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_rw_,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_idata,
    output logic                  bus_rw_,
    input  logic [DATA_WIDTH-1:0] bus_odata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    arb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic                  m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_idata_q, bus_idata_d;
    logic                  bus_rw_q, bus_rw_d;

    logic                  sel_valid, sel_winner;
    logic [BW-1:0]         sel_burst;

    arb_select #(.MAX_BURST(MAX_BURST), .BW(BW)) u_select (
        .m0_req         (m0_req),
        .m1_req         (m1_req),
        .last           (last_q),
        .burst_cnt      (burst_q),
        .valid          (sel_valid),
        .winner         (sel_winner),
        .next_burst_cnt (sel_burst)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_d     = burst_q;
        cyc_d       = cyc_q;
        m0_gnt_d    = m0_gnt_q;
        m1_gnt_d    = m1_gnt_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_idata_d = bus_idata_q;
        bus_rw_d    = bus_rw_q;

        case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    state_d = ARB_ACCESS;
                    last_d  = sel_winner;
                    burst_d = sel_burst;
                    cyc_d   = CW'(ACCESS_CYCLES - 1);
                    if (sel_winner == ARB_M1) begin
                        bus_addr_d  = m1_addr;
                        bus_idata_d = m1_wdata;
                        bus_rw_d    = m1_rw_;
                        m1_gnt_d    = 1'b1;
                    end else begin
                        bus_addr_d  = m0_addr;
                        bus_idata_d = m0_wdata;
                        bus_rw_d    = m0_rw_;
                        m0_gnt_d    = 1'b1;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CW'(1);
                end else begin
                    // last_q still names the owner of the access being completed.
                    if (bus_rw_q == RW_READ) begin
                        if (last_q == ARB_M1) m1_rdata_d = bus_odata;
                        else                  m0_rdata_d = bus_odata;
                    end
                    if (last_q == ARB_M1) m1_ack_d = 1'b1;
                    else                  m0_ack_d = 1'b1;
                    m0_gnt_d    = 1'b0;
                    m1_gnt_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_idata_d = '0;
                    bus_rw_d    = RW_READ;
                    state_d     = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_q      <= ARB_M1;
            burst_q     <= '0;
            cyc_q       <= '0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            bus_addr_q  <= '0;
            bus_idata_q <= '0;
            bus_rw_q    <= RW_READ;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            cyc_q       <= cyc_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_idata_q <= bus_idata_d;
            bus_rw_q    <= bus_rw_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_idata = bus_idata_q;
    assign bus_rw_   = bus_rw_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a memory-backed device model, a scoreboard of expected
// transactions in grant order, and a second instance built with ACCESS_CYCLES=1.
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic          mst;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance (ACCESS_CYCLES=2, MAX_BURST=4)
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_rw_ = 1'b1, m1_rw_ = 1'b1;
    logic          m0_gnt, m1_gnt, m0_ack, m1_ack, bus_rw_;
    logic [DW-1:0] m0_rdata, m1_rdata, bus_idata, bus_odata;
    logic [AW-1:0] bus_addr;

    // Single-cycle access instance
    logic          c_m0_req = 1'b0, c_m1_req = 1'b0;
    logic [AW-1:0] c_m0_addr = '0, c_m1_addr = '0;
    logic [DW-1:0] c_m0_wdata = '0, c_m1_wdata = '0;
    logic          c_m0_rw_ = 1'b1, c_m1_rw_ = 1'b1;
    logic          c_m0_gnt, c_m1_gnt, c_m0_ack, c_m1_ack, c_bus_rw_;
    logic [DW-1:0] c_m0_rdata, c_m1_rdata, c_bus_idata, c_bus_odata;
    logic [AW-1:0] c_bus_addr;

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(2), .MAX_BURST(4)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw_(m0_rw_),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw_(m1_rw_),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_idata(bus_idata), .bus_rw_(bus_rw_), .bus_odata(bus_odata)
    );

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1), .MAX_BURST(4)) u_dut_c1 (
        .clk(clk), .reset(reset),
        .m0_req(c_m0_req), .m0_addr(c_m0_addr), .m0_wdata(c_m0_wdata), .m0_rw_(c_m0_rw_),
        .m1_req(c_m1_req), .m1_addr(c_m1_addr), .m1_wdata(c_m1_wdata), .m1_rw_(c_m1_rw_),
        .m0_gnt(c_m0_gnt), .m0_ack(c_m0_ack), .m0_rdata(c_m0_rdata),
        .m1_gnt(c_m1_gnt), .m1_ack(c_m1_ack), .m1_rdata(c_m1_rdata),
        .bus_addr(c_bus_addr), .bus_idata(c_bus_idata), .bus_rw_(c_bus_rw_), .bus_odata(c_bus_odata)
    );

    // Device model: memory preloaded with 'hA000+index, location 5 holds 'h1234
    logic [DW-1:0] mem [0:255];
    assign bus_odata   = mem[bus_addr[7:0]];
    assign c_bus_odata = mem[c_bus_addr[7:0]];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
            mem[5] = 16'h1234;
        end else if ((m0_gnt || m1_gnt) && !bus_rw_) begin
            mem[bus_addr[7:0]] = bus_idata;
        end
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    txn_t sb[$];
    logic [DW-1:0] exp_rdata [2];
    int   done_cnt [2];
    logic mon_en = 1'b0;
    logic ack_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic mst, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.mst = mst; t.rd = rd; t.addr = a; t.data = d;
        sb.push_back(t);
    endtask

    // Scoreboard monitor: the head of sb is the access that owns (or will next own) the bus.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (ack_prev) check("post_ack_idle", {m1_gnt, m0_gnt}, 2'b00);
            if (m0_gnt || m1_gnt) begin
                if (sb.size() == 0) begin
                    check("gnt_unexpected", {m1_gnt, m0_gnt}, 2'b00);
                end else begin
                    check("gnt_owner", {m1_gnt, m0_gnt}, sb[0].mst ? 2'b10 : 2'b01);
                    check("bus_addr", bus_addr, sb[0].addr);
                    check("bus_rw_", bus_rw_, sb[0].rd);
                    if (!sb[0].rd) check("bus_idata", bus_idata, sb[0].data);
                end
            end else begin
                check("idle_rw_", bus_rw_, 1'b1);
            end
            if (m0_ack || m1_ack) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", {m1_ack, m0_ack}, 2'b00);
                end else begin
                    txn_t h;
                    h = sb.pop_front();
                    check("ack_owner", {m1_ack, m0_ack}, h.mst ? 2'b10 : 2'b01);
                    if (h.rd) exp_rdata[h.mst] = h.data;
                end
            end
            check("m0_rdata", m0_rdata, exp_rdata[0]);
            check("m1_rdata", m1_rdata, exp_rdata[1]);
            ack_prev = m0_ack || m1_ack;
        end else begin
            ack_prev = 1'b0;
        end
    end

    task automatic drive(input logic mst, input logic req, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (mst) begin m1_req = req; m1_rw_ = rd; m1_addr = a; m1_wdata = d; end
        else     begin m0_req = req; m0_rw_ = rd; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic access(input logic mst, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic keep);
        int   t;
        logic got;
        drive(mst, 1'b1, rd, a, d);
        t = 0; got = 1'b0;
        while (!got && t < 40) begin
            @(negedge clk);
            t++;
            got = mst ? m1_ack : m0_ack;
        end
        check("ack_wait", got, 1'b1);
        if (!keep) begin
            if (mst) m1_req = 1'b0; else m0_req = 1'b0;
        end
    endtask

    task automatic master_run(input logic mst, input int n, input logic [AW-1:0] base, input int n_solo);
        int prev;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            access(mst, 1'b1, base + AW'(i), '0, (i < n - 1));
            if (i > 0 && i < n_solo) check("solo_throughput", cyc - prev, 4);
            prev = cyc;
            done_cnt[mst]++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        done_cnt[0] = 0;   done_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of both instances
        @(negedge clk);
        check("rst_gnt",   {m1_gnt, m0_gnt, m1_ack, m0_ack}, 4'b0000);
        check("rst_rdata", {m1_rdata, m0_rdata}, 32'h0);
        check("rst_bus",   {bus_addr, bus_idata}, 32'h0);
        check("rst_rw_",   bus_rw_, 1'b1);
        check("rst_c1",    {c_m0_gnt, c_m1_gnt, c_m0_ack, c_m1_ack, c_bus_rw_}, 5'b00001);
        mon_en = 1'b1;

        // Single read with explicit latency
        push(1'b0, 1'b1, 16'h0005, 16'h1234);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 16'h0005, '0);
        @(negedge clk); check("lat_c0_gnt", m0_gnt, 1'b0);
        @(negedge clk); check("lat_c1_gnt", {m0_gnt, m0_ack}, 2'b10);
        check("lat_c1_bus", {bus_rw_, bus_addr}, {1'b1, 16'h0005});
        @(negedge clk); check("lat_c2_gnt", {m0_gnt, m0_ack}, 2'b10);
        @(negedge clk); check("lat_c3_ack", {m0_gnt, m0_ack}, 2'b01);
        check("lat_c3_rdata", m0_rdata, 16'h1234);
        check("lat_m1_quiet", {m1_gnt, m1_ack, m1_rdata}, 18'h0);
        m0_req = 1'b0;
        @(negedge clk); check("lat_c4_ack", m0_ack, 1'b0);

        // Write then read on m1
        push(1'b1, 1'b0, 16'h0050, 16'hBEEF);
        push(1'b1, 1'b1, 16'h0050, 16'hBEEF);
        access(1'b1, 1'b0, 16'h0050, 16'hBEEF, 1'b0);
        access(1'b1, 1'b1, 16'h0050, '0, 1'b0);
        repeat (2) @(negedge clk);

        // Contention from reset: m0 x4, m1 x4, m0 x4, then m1 alone
        @(posedge clk); #1;
        reset = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 16'h0010 + 16'(i), 16'hA010 + 16'(i));
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 16'h0020 + 16'(i), 16'hA020 + 16'(i));
        for (int i = 4; i < 8; i++) push(1'b0, 1'b1, 16'h0010 + 16'(i), 16'hA010 + 16'(i));
        for (int i = 4; i < 6; i++) push(1'b1, 1'b1, 16'h0020 + 16'(i), 16'hA020 + 16'(i));
        drive(1'b0, 1'b1, 1'b1, 16'h0010, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h0020, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            master_run(1'b0, 8, 16'h0010, 0);
            master_run(1'b1, 6, 16'h0020, 0);
        join
        repeat (2) @(negedge clk);
        check("contention_drain", sb.size(), 0);

        // Lone master saturates its burst; m1 then wins the next arbitration
        done_cnt[0] = 0;
        for (int i = 0; i < 10; i++) push(1'b0, 1'b1, 16'h0030 + 16'(i), 16'hA030 + 16'(i));
        push(1'b1, 1'b1, 16'h0040, 16'hA040);
        push(1'b0, 1'b1, 16'h003A, 16'hA03A);
        push(1'b0, 1'b1, 16'h003B, 16'hA03B);
        fork
            master_run(1'b0, 12, 16'h0030, 10);
            begin
                int t;
                t = 0;
                while (done_cnt[0] < 10 && t < 2000) begin @(negedge clk); t++; end
                check("lone_wait", (done_cnt[0] >= 10), 1'b1);
                access(1'b1, 1'b1, 16'h0040, '0, 1'b0);
            end
        join
        repeat (2) @(negedge clk);
        check("lone_drain", sb.size(), 0);

        // Reset during the first ACCESS cycle of an m0 write
        push(1'b0, 1'b0, 16'h0070, 16'hDEAD);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 16'h0070, 16'hDEAD);
        begin
            int t;
            t = 0;
            do begin @(posedge clk); #1; t++; end while (!m0_gnt && t < 20);
            check("rstw_gnt_seen", m0_gnt, 1'b1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        drive(1'b0, 1'b0, 1'b1, '0, '0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(negedge clk);
        check("rstw_gnt_ack", {m1_gnt, m0_gnt, m1_ack, m0_ack}, 4'b0000);
        check("rstw_bus", {bus_rw_, bus_addr}, {1'b1, 16'h0000});
        @(posedge clk); #1;
        push(1'b0, 1'b1, 16'h0061, 16'hA061);
        push(1'b1, 1'b1, 16'h0062, 16'hA062);
        drive(1'b0, 1'b1, 1'b1, 16'h0061, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h0062, '0);
        reset = 1'b0;
        fork
            access(1'b0, 1'b1, 16'h0061, '0, 1'b0);
            access(1'b1, 1'b1, 16'h0062, '0, 1'b0);
        join
        repeat (3) @(negedge clk);
        check("rstw_drain", sb.size(), 0);

        // ACCESS_CYCLES=1 instance: 1-cycle gnt, ack in cycle 2, 3-cycle throughput
        @(posedge clk); #1;
        c_m0_req = 1'b1; c_m0_rw_ = 1'b1; c_m0_addr = 16'h0007;
        @(negedge clk); check("c1_c0_gnt", c_m0_gnt, 1'b0);
        @(negedge clk); check("c1_c1_gnt", {c_m0_gnt, c_m0_ack}, 2'b10);
        check("c1_c1_bus", {c_bus_rw_, c_bus_addr}, {1'b1, 16'h0007});
        @(negedge clk); check("c1_c2_ack", {c_m0_gnt, c_m0_ack}, 2'b01);
        check("c1_c2_rdata", c_m0_rdata, 16'hA007);
        c_m0_addr = 16'h0008;
        @(negedge clk); check("c1_c3_idle", {c_m0_gnt, c_m0_ack}, 2'b00);
        @(negedge clk); check("c1_c4_gnt", {c_m0_gnt, c_m0_ack}, 2'b10);
        @(negedge clk); check("c1_c5_ack", {c_m0_gnt, c_m0_ack}, 2'b01);
        check("c1_c5_rdata", c_m0_rdata, 16'hA008);
        check("c1_m1_quiet", {c_m1_gnt, c_m1_ack}, 2'b00);
        c_m0_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
